sccb_init_sequencer: RTL and testbench
======================================

Name: sccb_init_sequencer

Overview:
- Drives the SCCB master through the camera power-up and register-initialisation sequence.
- Pulses the camera hardware reset, then walks a register table in ROM and issues one 3-phase write per entry.
- Optionally reads each register back to check the written value, and honours delay entries placed in the table.
- Sits between the RISC-V control fabric (go/status) and the SCCB master core (start/rw/addr/data/done).

Parameters:
- CAM_ID, 7'h21: 7-bit SCCB device ID, driven on sccb_id_addr.
- ROM_AW, 8: table address width.
- RST_CYCLES, 1000: clk cycles that cam_rstn is held low.
- PWRUP_CYCLES, 3000: clk cycles to wait after cam_rstn rises, before the first command.
- DELAY_UNIT, 100: clk cycles per delay-entry tick.
- TIMEOUT, 65535: maximum clk cycles spent in any single wait-for-done state.
- VERIFY, 0: 1 enables the read-back compare after each write.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- go  in  1  start-sequence pulse, sampled in IDLE only.
- busy  out  1  high whenever state is not IDLE.
- init_done  out  1  sticky; set when the end marker is reached without error.
- error  out  1  sticky; set on timeout or verify mismatch.
- err_index  out  ROM_AW  table index of the failing entry.
- rom_addr  out  ROM_AW  table address.
- rom_data  in  16  entry {sub_addr[15:8], data[7:0]}; valid 1 cycle after rom_addr.
- sccb_start  out  1  command request to the SCCB master.
- sccb_rw  out  1  0 = write, 1 = read.
- sccb_id_addr  out  7  always CAM_ID.
- sccb_sub_addr  out  8  register address.
- sccb_data_in  out  8  write data.
- sccb_data_out  in  8  read data from the SCCB master.
- sccb_done  in  1  command-complete level from the SCCB master (may span many clk cycles).
- cam_rstn  out  1  camera hardware reset, active low.

Behaviour:
- Reset values (async, resetn low):
  - State IDLE.
  - busy, init_done, error, sccb_start, sccb_rw = 0.
  - err_index, rom_addr, sccb_sub_addr, sccb_data_in = 0.
  - cam_rstn = 1.
  - All counters 0.
- Entry decode:
  - 16'hFFFF: end marker.
  - 8'hF0 in the high byte: delay of data × DELAY_UNIT cycles; data = 0 means no delay.
  - Anything else: register write.
- go while not IDLE is ignored. go in IDLE clears init_done, error, err_index and rom_addr, then moves to RST_LOW.
- State sequence:
  - RST_LOW: cam_rstn = 0 for RST_CYCLES cycles, then RST_WAIT.
  - RST_WAIT: cam_rstn = 1 for PWRUP_CYCLES cycles, then FETCH.
  - FETCH: present rom_addr for 1 cycle, then DECODE (rom_data is valid in DECODE).
  - DECODE: end marker → FINISH. Delay entry → load counter, go to DELAY. Write entry → latch sub_addr and data onto the sccb_* outputs, set sccb_rw = 0, go to CMD.
  - CMD: sccb_start = 1, then WAIT_HI.
  - WAIT_HI: sccb_start is held at 1 until sccb_done = 1, then deasserted and the state moves to WAIT_LO.
  - WAIT_LO: wait for sccb_done = 0.
    - If VERIFY = 1 and the command just completed was the write → set sccb_rw = 1, go to CMD (read-back).
    - If the command just completed was the read → go to CHECK.
    - Otherwise → NEXT.
  - CHECK: sccb_data_out ≠ latched data → ERROR; equal → NEXT.
  - DELAY: count down to 0, then NEXT.
  - NEXT: rom_addr + 1, then FETCH. At rom_addr = 2^ROM_AW − 1 without an end marker, go to FINISH instead of wrapping.
  - FINISH: init_done = 1, then IDLE.
  - ERROR: error = 1, err_index = rom_addr, sccb_start = 0, then IDLE. cam_rstn stays 1.
- Command handshake:
  - sccb_start and the sccb_* fields are stable for the whole WAIT_HI period.
  - The sequencer never issues a new command while sccb_done = 1.
- Timeout: a cycle counter is cleared on entry to WAIT_HI and to WAIT_LO. Reaching TIMEOUT in either state → ERROR.
- Reset mid-operation: returns to the reset values immediately; cam_rstn goes back to 1.
- Counters are wide enough for their parameter: ≥17 bits for TIMEOUT, and wide enough for 255 × DELAY_UNIT.

Test Plan:
- Table {12'h80 write 0x12, FFFF}, VERIFY = 0, model core raises done 20 cycles after start → cam_rstn low for exactly 1000 cycles; first sccb_start 3000 cycles after cam_rstn rises; one write with sub 0x12, data 0x80, rw 0; then init_done = 1, busy = 0.
- Table {F005, 1140, FFFF} → 500-cycle gap before the write of reg 0x11 = 0x40; delay entries never assert sccb_start.
- VERIFY = 1, model returns 0x40 for the 0x40 write → write followed by a read (rw 1), init_done = 1. Model returns 0x41 → error = 1, err_index = 0, init_done = 0.
- Model never raises done → error after exactly TIMEOUT cycles in WAIT_HI, sccb_start returns to 0.
- done held high 50 cycles → exactly one command issued per entry; next start only after done falls.
- resetn low during WAIT_HI → all outputs at reset values at once. go pulsed while busy → ignored.

Source files
------------

// File: rtl/sccb_init_sequencer.sv
// Camera bring-up sequencer: pulses cam_rstn, then replays a ROM register table as SCCB writes.
// Latency: RST_CYCLES + PWRUP_CYCLES before the first command, then about 3 cycles plus core time per entry.
// Backpressure: each command waits for sccb_done to rise and then fall; a stuck phase ends in ERROR after TIMEOUT.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   go / busy            start pulse (ignored unless idle) / sequence in progress
//   init_done, error     sticky completion / failure flags; err_index = failing table index
//   rom_addr, rom_data   table read port; data valid one cycle after the address
//   sccb_*               command to the SCCB master core; sccb_done is a level that may last many cycles
//   cam_rstn             camera hardware reset, active low
module sccb_init_sequencer #(
   parameter logic [6:0] CAM_ID       = 7'h21,
   parameter int         ROM_AW       = 8,
   parameter int         RST_CYCLES   = 1000,
   parameter int         PWRUP_CYCLES = 3000,
   parameter int         DELAY_UNIT   = 100,
   parameter int         TIMEOUT      = 65535,
   parameter int         VERIFY       = 0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              go,
   output logic              busy,
   output logic              init_done,
   output logic              error,
   output logic [ROM_AW-1:0] err_index,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              sccb_start,
   output logic              sccb_rw,
   output logic [6:0]        sccb_id_addr,
   output logic [7:0]        sccb_sub_addr,
   output logic [7:0]        sccb_data_in,
   input  logic [7:0]        sccb_data_out,
   input  logic              sccb_done,
   output logic              cam_rstn
);

   // One shared counter serves every timed state; size it for the largest interval, never below 17 bits.
   localparam int MAX_A  = (TIMEOUT > 255 * DELAY_UNIT) ? TIMEOUT : 255 * DELAY_UNIT;
   localparam int MAX_B  = (RST_CYCLES > PWRUP_CYCLES) ? RST_CYCLES : PWRUP_CYCLES;
   localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW_RAW = $clog2(MAX_C + 1);
   localparam int CW     = (CW_RAW < 17) ? 17 : CW_RAW;

   typedef enum logic [3:0] {
      S_IDLE, S_RST_LOW, S_RST_WAIT, S_FETCH, S_DECODE, S_CMD, S_WAIT_HI,
      S_WAIT_LO, S_CHECK, S_DELAY, S_NEXT, S_FINISH, S_ERROR
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic          is_end, is_delay;

   assign is_end       = (rom_data == 16'hFFFF);
   assign is_delay     = (rom_data[15:8] == 8'hF0);
   assign sccb_id_addr = CAM_ID;

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (go) state_nxt = S_RST_LOW;
         S_RST_LOW:  if (cnt == CW'(RST_CYCLES - 1)) state_nxt = S_RST_WAIT;
         S_RST_WAIT: if (cnt == CW'(PWRUP_CYCLES - 1)) state_nxt = S_FETCH;
         S_FETCH:    state_nxt = S_DECODE;
         S_DECODE: begin
            if (is_end)                         state_nxt = S_FINISH;
            else if (is_delay && rom_data[7:0] == 8'h00) state_nxt = S_NEXT;
            else if (is_delay)                  state_nxt = S_DELAY;
            else                                state_nxt = S_CMD;
         end
         S_CMD:      state_nxt = S_WAIT_HI;
         S_WAIT_HI: begin
            if (sccb_done)                        state_nxt = S_WAIT_LO;
            else if (cnt == CW'(TIMEOUT - 1))     state_nxt = S_ERROR;
         end
         S_WAIT_LO: begin
            // sccb_rw still tells which command just completed
            if (!sccb_done) begin
               if (VERIFY != 0 && !sccb_rw) state_nxt = S_CMD;
               else if (sccb_rw)            state_nxt = S_CHECK;
               else                         state_nxt = S_NEXT;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               state_nxt = S_ERROR;
            end
         end
         S_CHECK:    state_nxt = (sccb_data_out != sccb_data_in) ? S_ERROR : S_NEXT;
         S_DELAY:    if (cnt == '0) state_nxt = S_NEXT;
         // Stop at the top of the table rather than wrapping back onto entry 0
         S_NEXT:     state_nxt = (rom_addr == {ROM_AW{1'b1}}) ? S_FINISH : S_FETCH;
         S_FINISH:   state_nxt = S_IDLE;
         S_ERROR:    state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Counter, table pointer, command fields and sticky status
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt           <= '0;
         rom_addr      <= '0;
         err_index     <= '0;
         init_done     <= 1'b0;
         error         <= 1'b0;
         sccb_rw       <= 1'b0;
         sccb_sub_addr <= 8'h00;
         sccb_data_in  <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (go) begin
                  init_done <= 1'b0;
                  error     <= 1'b0;
                  err_index <= '0;
                  rom_addr  <= '0;
               end
            end
            S_RST_LOW, S_RST_WAIT, S_WAIT_HI:
               cnt <= (state_nxt == state) ? cnt + CW'(1) : '0;
            S_WAIT_LO: begin
               cnt <= (state_nxt == state) ? cnt + CW'(1) : '0;
               if (state_nxt == S_CMD) sccb_rw <= 1'b1;
            end
            S_DECODE: begin
               cnt <= '0;
               if (is_delay && rom_data[7:0] != 8'h00) begin
                  // DELAY lasts exactly data*DELAY_UNIT cycles while counting down to zero
                  cnt <= CW'(rom_data[7:0]) * CW'(DELAY_UNIT) - CW'(1);
               end else if (!is_end && !is_delay) begin
                  sccb_sub_addr <= rom_data[15:8];
                  sccb_data_in  <= rom_data[7:0];
                  sccb_rw       <= 1'b0;
               end
            end
            S_DELAY:  if (cnt != '0) cnt <= cnt - CW'(1);
            S_NEXT: begin
               cnt <= '0;
               if (state_nxt == S_FETCH) rom_addr <= rom_addr + 1'b1;
            end
            S_FINISH: init_done <= 1'b1;
            S_ERROR: begin
               error     <= 1'b1;
               err_index <= rom_addr;
            end
            default:  cnt <= '0;
         endcase
      end
   end

   // Outputs decoded from state
   always_comb begin
      busy       = (state != S_IDLE);
      cam_rstn   = (state != S_RST_LOW);
      sccb_start = (state == S_CMD) || (state == S_WAIT_HI);
   end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Directed bench for sccb_init_sequencer: two instances (VERIFY off with full reset timing,
// VERIFY on with shortened reset timing), a registered ROM per instance and an SCCB core model.
module tb_sccb_init_sequencer;

   localparam int TMO = 300;

   logic        clk;
   logic        resetn;
   logic [1:0]  go_s, busy_s, init_done_s, error_s, start_s, rw_s, done_s, camr_s;
   logic [7:0]  err_index_s [2];
   logic [7:0]  rom_addr_s  [2];
   logic [15:0] rom_data_s  [2];
   logic [6:0]  id_s        [2];
   logic [7:0]  sub_s       [2];
   logic [7:0]  din_s       [2];
   logic [7:0]  dout_s      [2];

   logic [15:0] rom0 [256];
   logic [15:0] rom1 [256];

   int passed = 0;
   int total  = 0;

   sccb_init_sequencer #(.TIMEOUT(TMO), .VERIFY(0)) dut (
      .clk(clk), .resetn(resetn), .go(go_s[0]), .busy(busy_s[0]),
      .init_done(init_done_s[0]), .error(error_s[0]), .err_index(err_index_s[0]),
      .rom_addr(rom_addr_s[0]), .rom_data(rom_data_s[0]), .sccb_start(start_s[0]),
      .sccb_rw(rw_s[0]), .sccb_id_addr(id_s[0]), .sccb_sub_addr(sub_s[0]),
      .sccb_data_in(din_s[0]), .sccb_data_out(dout_s[0]), .sccb_done(done_s[0]),
      .cam_rstn(camr_s[0]));

   sccb_init_sequencer #(.RST_CYCLES(10), .PWRUP_CYCLES(20), .TIMEOUT(TMO), .VERIFY(1)) dut_v (
      .clk(clk), .resetn(resetn), .go(go_s[1]), .busy(busy_s[1]),
      .init_done(init_done_s[1]), .error(error_s[1]), .err_index(err_index_s[1]),
      .rom_addr(rom_addr_s[1]), .rom_data(rom_data_s[1]), .sccb_start(start_s[1]),
      .sccb_rw(rw_s[1]), .sccb_id_addr(id_s[1]), .sccb_sub_addr(sub_s[1]),
      .sccb_data_in(din_s[1]), .sccb_data_out(dout_s[1]), .sccb_done(done_s[1]),
      .cam_rstn(camr_s[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Table ROMs: data one cycle after address
   always @(posedge clk) begin
      rom_data_s[0] <= rom0[rom_addr_s[0]];
      rom_data_s[1] <= rom1[rom_addr_s[1]];
   end

   // SCCB core model: done rises lat cycles after start, stays high hold cycles
   int         lat   [2];
   int         hold  [2];
   int         never [2];
   logic [7:0] rdval [2];
   int         ph    [2];
   int         mc    [2];
   int         ncmd  [2];
   int         viol  [2];
   logic       cmd_rw  [2][8];
   logic [7:0] cmd_sub [2][8];
   logic [7:0] cmd_dat [2][8];

   initial begin
      for (int i = 0; i < 2; i++) begin
         ph[i] = 0; mc[i] = 0; ncmd[i] = 0; viol[i] = 0;
         dout_s[i] = 8'h00;
      end
      done_s = 2'b00;
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!resetn) begin
            ph[i] = 0; mc[i] = 0; done_s[i] = 1'b0;
         end else begin
            case (ph[i])
               0: if (start_s[i]) begin
                     cmd_rw[i][ncmd[i] % 8]  = rw_s[i];
                     cmd_sub[i][ncmd[i] % 8] = sub_s[i];
                     cmd_dat[i][ncmd[i] % 8] = din_s[i];
                     ncmd[i]++;
                     ph[i] = 1; mc[i] = 0;
                  end
               1: begin
                     mc[i]++;
                     if (!start_s[i]) ph[i] = 0;
                     else if (mc[i] >= lat[i] && never[i] == 0) begin
                        done_s[i] = 1'b1;
                        dout_s[i] = rw_s[i] ? rdval[i] : 8'h00;
                        ph[i] = 2; mc[i] = 0;
                     end
                  end
               default: begin
                     // start must stay low while done is still high
                     if (start_s[i]) viol[i]++;
                     mc[i]++;
                     if (mc[i] >= hold[i]) begin
                        done_s[i] = 1'b0; ph[i] = 0;
                     end
                  end
            endcase
         end
      end
   end

   // Timing monitor on instance 0
   int   cyc = 0, low_run = 0, hi_run = 0, rise_cyc = 0, first_start = 0, starts_since = 0;
   logic prev_camr = 1'b1, prev_start = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (!camr_s[0]) low_run = prev_camr ? 1 : low_run + 1;
      if (camr_s[0] && !prev_camr) begin
         rise_cyc = cyc; starts_since = 0;
      end
      if (start_s[0]) begin
         if (!prev_start) begin
            hi_run = 1;
            if (starts_since == 0) first_start = cyc;
            starts_since++;
         end else hi_run++;
      end
      prev_camr  = camr_s[0];
      prev_start = start_s[0];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic go_pulse(input int i);
      @(negedge clk); go_s[i] = 1'b1;
      @(negedge clk); go_s[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i, input int budget);
      int n = 0;
      while (busy_s[i] && n < budget) begin @(negedge clk); n++; end
      check("idle_reached", {31'd0, busy_s[i]}, 0);
   endtask

   int base;

   initial begin
      resetn = 1'b0;
      go_s   = 2'b00;
      for (int k = 0; k < 256; k++) begin rom0[k] = 16'hFFFF; rom1[k] = 16'hFFFF; end
      for (int i = 0; i < 2; i++) begin lat[i] = 20; hold[i] = 3; never[i] = 0; rdval[i] = 8'h00; end
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_busy",      {31'd0, busy_s[0]},      0);
      check("rst_init_done", {31'd0, init_done_s[0]}, 0);
      check("rst_error",     {31'd0, error_s[0]},     0);
      check("rst_start",     {31'd0, start_s[0]},     0);
      check("rst_rw",        {31'd0, rw_s[0]},        0);
      check("rst_fields",    {err_index_s[0], rom_addr_s[0], sub_s[0], din_s[0]}, 0);
      check("rst_cam_rstn",  {31'd0, camr_s[0]},      1);
      check("rst_id",        {25'd0, id_s[0]},        32'h21);
      resetn = 1'b1;

      // A: single write, go re-pulsed during RST_LOW must be ignored
      rom0[0] = 16'h1280; rom0[1] = 16'hFFFF;
      base = ncmd[0];
      go_pulse(0);
      repeat (500) @(negedge clk);
      go_pulse(0);
      wait_idle(0, 8000);
      check("A_rst_low_len", low_run, 1000);
      // RST_WAIT 3000 cycles, then FETCH and DECODE before CMD raises start
      check("A_start_after_rise", first_start - rise_cyc, 3002);
      check("A_ncmd", ncmd[0] - base, 1);
      check("A_cmd", {cmd_rw[0][base % 8], cmd_sub[0][base % 8], cmd_dat[0][base % 8]}, {1'b0, 8'h12, 8'h80});
      check("A_init_done", {31'd0, init_done_s[0]}, 1);
      check("A_error", {31'd0, error_s[0]}, 0);

      // B: 5*100-cycle delay entry, then write 0x11=0x40
      rom0[0] = 16'hF005; rom0[1] = 16'h1140; rom0[2] = 16'hFFFF;
      base = ncmd[0];
      go_pulse(0);
      wait_idle(0, 8000);
      // 3000 + FETCH,DECODE + 500 DELAY + NEXT + FETCH,DECODE
      check("B_start_after_rise", first_start - rise_cyc, 3505);
      check("B_ncmd", ncmd[0] - base, 1);
      check("B_cmd", {cmd_rw[0][base % 8], cmd_sub[0][base % 8], cmd_dat[0][base % 8]}, {1'b0, 8'h11, 8'h40});
      check("B_init_done", {31'd0, init_done_s[0]}, 1);

      // E: core never answers -> timeout in WAIT_HI
      rom0[0] = 16'h1280; rom0[1] = 16'hFFFF;
      never[0] = 1;
      go_pulse(0);
      wait_idle(0, 8000);
      never[0] = 0;
      check("E_start_high_len", hi_run, TMO + 1);
      check("E_error", {31'd0, error_s[0]}, 1);
      check("E_start_low", {31'd0, start_s[0]}, 0);
      check("E_init_done", {31'd0, init_done_s[0]}, 0);
      check("E_err_index", {24'd0, err_index_s[0]}, 0);
      check("E_cam_rstn", {31'd0, camr_s[0]}, 1);

      // F: done held 50 cycles, three writes
      rom0[0] = 16'h1111; rom0[1] = 16'h2222; rom0[2] = 16'h3333; rom0[3] = 16'hFFFF;
      hold[0] = 50;
      base = ncmd[0];
      go_pulse(0);
      wait_idle(0, 8000);
      hold[0] = 3;
      check("F_ncmd", ncmd[0] - base, 3);
      check("F_no_start_during_done", viol[0], 0);
      check("F_cmds", {cmd_sub[0][base % 8], cmd_sub[0][(base + 1) % 8], cmd_sub[0][(base + 2) % 8]}, 32'h112233);
      check("F_init_done", {31'd0, init_done_s[0]}, 1);
      check("F_error", {31'd0, error_s[0]}, 0);

      // H: reset asserted during WAIT_HI
      rom0[0] = 16'h1280; rom0[1] = 16'hFFFF;
      go_pulse(0);
      for (int n = 0; n < 6000 && !start_s[0]; n++) @(negedge clk);
      check("H_start_seen", {31'd0, start_s[0]}, 1);
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      #1;
      check("H_busy", {31'd0, busy_s[0]}, 0);
      check("H_start", {31'd0, start_s[0]}, 0);
      check("H_cam_rstn", {31'd0, camr_s[0]}, 1);
      check("H_fields", {rom_addr_s[0], sub_s[0], din_s[0], 7'd0, init_done_s[0]}, 0);
      @(negedge clk); resetn = 1'b1;

      // C: VERIFY, read-back matches
      rom1[0] = 16'h2A40; rom1[1] = 16'hFFFF;
      rdval[1] = 8'h40;
      base = ncmd[1];
      go_pulse(1);
      wait_idle(1, 3000);
      check("C_ncmd", ncmd[1] - base, 2);
      check("C_cmds", {7'd0, cmd_rw[1][base % 8], 7'd0, cmd_rw[1][(base + 1) % 8], cmd_sub[1][(base + 1) % 8]}, 32'h0000_012A);
      check("C_init_done", {31'd0, init_done_s[1]}, 1);
      check("C_error", {31'd0, error_s[1]}, 0);

      // D: VERIFY, read-back mismatch on entry 0
      rdval[1] = 8'h41;
      go_pulse(1);
      wait_idle(1, 3000);
      check("D_error", {31'd0, error_s[1]}, 1);
      check("D_err_index", {24'd0, err_index_s[1]}, 0);
      check("D_init_done", {31'd0, init_done_s[1]}, 0);

      // D2: entry 0 verifies, entry 1 mismatches
      rom1[0] = 16'h2A40; rom1[1] = 16'h3355; rom1[2] = 16'hFFFF;
      rdval[1] = 8'h40;
      go_pulse(1);
      wait_idle(1, 3000);
      check("D2_error", {31'd0, error_s[1]}, 1);
      check("D2_err_index", {24'd0, err_index_s[1]}, 1);

      // G: table of zero delays with no end marker stops at the last address
      for (int k = 0; k < 256; k++) rom1[k] = 16'hF000;
      base = ncmd[1];
      go_pulse(1);
      wait_idle(1, 3000);
      check("G_init_done", {31'd0, init_done_s[1]}, 1);
      check("G_rom_addr", {24'd0, rom_addr_s[1]}, 32'hFF);
      check("G_ncmd", ncmd[1] - base, 0);
      check("G_error", {31'd0, error_s[1]}, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
